plab5_mcore_mem_req_tracker: RTL and testbench

PLAB5_MCORE_MEM_REQ_TRACKER -- requirements
Module: plab5_mcore_mem_req_tracker

---
 rtl/plab5_mcore_mem_req_tracker.sv | 177 +++++++++++++++++
 tb/tb_plab5_mcore_mem_req_tracker.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/plab5_mcore_mem_req_tracker.sv
// Memory request tracker between a core and MemNet. It keeps a 1-entry request pipe,
// a FIFO of in-flight request domains, and a 2-entry response FIFO that checks the domain.
module plab5_mcore_mem_req_tracker #(
  parameter int p_mem_opaque_nbits = 8,
  parameter int p_mem_addr_nbits   = 32,
  parameter int p_mem_data_nbits   = 32,
  parameter int p_max_outstanding  = 4,
  localparam int c_rq = 3 + p_mem_opaque_nbits + p_mem_addr_nbits + 2 + p_mem_data_nbits,
  localparam int c_rs = 3 + p_mem_opaque_nbits + 2 + p_mem_data_nbits
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            mode,
  input  logic [c_rq-1:0] proc_req_msg,
  input  logic            proc_req_domain,
  input  logic            proc_req_val,
  output logic            proc_req_rdy,
  output logic [c_rq-1:0] net_req_msg,
  output logic            net_req_domain,
  output logic            net_req_val,
  input  logic            net_req_rdy,
  input  logic [c_rs-1:0] net_resp_msg,
  input  logic            net_resp_domain,
  input  logic            net_resp_fail,
  input  logic            net_resp_val,
  output logic            net_resp_rdy,
  output logic [c_rs-1:0] proc_resp_msg,
  output logic            proc_resp_domain,
  output logic            proc_resp_fail,
  output logic            proc_resp_val,
  input  logic            proc_resp_rdy,
  output logic [2:0]      outstanding,
  output logic [7:0]      fail_count,
  output logic            domain_err
);
  localparam int c_d     = p_mem_data_nbits;
  localparam int c_depth = p_max_outstanding;
  localparam int c_pw    = (c_depth > 1) ? $clog2(c_depth) : 1;

  logic            req_full_q, req_full_d;
  logic [c_rq-1:0] req_msg_q, req_msg_d;
  logic            req_dom_q, req_dom_d;
  logic            dfifo_q [c_depth];
  logic            dfifo_d [c_depth];
  logic [c_pw-1:0] dwr_q, dwr_d, drd_q, drd_d;
  logic [2:0]      outstanding_q, outstanding_d;
  logic [c_rs-1:0] rf_msg_q [2];
  logic [c_rs-1:0] rf_msg_d [2];
  logic            rf_dom_q [2];
  logic            rf_dom_d [2];
  logic            rf_fail_q [2];
  logic            rf_fail_d [2];
  logic            rf_wr_q, rf_wr_d, rf_rd_q, rf_rd_d;
  logic [1:0]      rf_cnt_q, rf_cnt_d;
  logic [7:0]      fail_count_q, fail_count_d;
  logic            domain_err_q, domain_err_d;

  logic            proc_req_fire, net_req_fire, net_resp_fire, proc_resp_fire;
  logic            have_out, enq, exp_dom, dom_mismatch;
  logic [c_rs-1:0] enq_msg;
  logic            enq_dom, enq_fail;

  assign net_req_val    = req_full_q;
  assign net_req_msg    = req_msg_q;
  assign net_req_domain = req_dom_q;
  assign proc_req_rdy   = (!req_full_q || net_req_rdy) &&
                          (({1'b0, outstanding_q} + {3'b000, req_full_q}) < 4'(c_depth));
  assign net_resp_rdy   = (rf_cnt_q != 2'd2);
  assign proc_resp_val  = (rf_cnt_q != 2'd0);
  assign proc_resp_msg    = rf_msg_q[rf_rd_q];
  assign proc_resp_domain = rf_dom_q[rf_rd_q];
  assign proc_resp_fail   = rf_fail_q[rf_rd_q];
  assign outstanding    = outstanding_q;
  assign fail_count     = fail_count_q;
  assign domain_err     = domain_err_q;

  assign proc_req_fire  = proc_req_val && proc_req_rdy;
  assign net_req_fire   = net_req_val && net_req_rdy;
  assign net_resp_fire  = net_resp_val && net_resp_rdy;
  assign proc_resp_fire = proc_resp_val && proc_resp_rdy;
  assign have_out       = (outstanding_q != 3'd0);
  assign enq            = net_resp_fire && have_out;
  assign exp_dom        = dfifo_q[drd_q];
  assign dom_mismatch   = mode && (net_resp_domain != exp_dom);

  always_comb begin
    req_full_d = req_full_q;
    req_msg_d  = req_msg_q;
    req_dom_d  = req_dom_q;
    if (proc_req_fire) begin
      req_full_d = 1'b1;
      req_msg_d  = proc_req_msg;
      req_dom_d  = proc_req_domain;
    end else if (net_req_fire) begin
      req_full_d = 1'b0;
    end

    // A domain mismatch takes priority over a network fail and reports the expected domain.
    enq_msg  = net_resp_msg;
    enq_dom  = net_resp_domain;
    enq_fail = net_resp_fail;
    if (dom_mismatch) begin
      enq_msg  = {net_resp_msg[c_rs-1:c_d], {c_d{1'b0}}};
      enq_dom  = exp_dom;
      enq_fail = 1'b1;
    end else if (net_resp_fail) begin
      enq_msg  = {net_resp_msg[c_rs-1:c_d], {c_d{1'b0}}};
      enq_fail = 1'b1;
    end

    dfifo_d = dfifo_q;
    dwr_d   = dwr_q;
    drd_d   = drd_q;
    if (net_req_fire) begin
      dfifo_d[dwr_q] = req_dom_q;
      dwr_d = (dwr_q == c_pw'(c_depth - 1)) ? '0 : dwr_q + 1'b1;
    end
    if (enq) drd_d = (drd_q == c_pw'(c_depth - 1)) ? '0 : drd_q + 1'b1;
    outstanding_d = outstanding_q + 3'(net_req_fire) - 3'(enq);

    rf_msg_d  = rf_msg_q;
    rf_dom_d  = rf_dom_q;
    rf_fail_d = rf_fail_q;
    rf_wr_d   = rf_wr_q;
    rf_rd_d   = rf_rd_q;
    if (enq) begin
      rf_msg_d[rf_wr_q]  = enq_msg;
      rf_dom_d[rf_wr_q]  = enq_dom;
      rf_fail_d[rf_wr_q] = enq_fail;
      rf_wr_d = ~rf_wr_q;
    end
    if (proc_resp_fire) rf_rd_d = ~rf_rd_q;
    rf_cnt_d = rf_cnt_q + 2'(enq) - 2'(proc_resp_fire);

    fail_count_d = fail_count_q;
    if (enq && enq_fail && (fail_count_q != 8'hff)) fail_count_d = fail_count_q + 8'd1;
    domain_err_d = domain_err_q || (enq && dom_mismatch) || (net_resp_fire && !have_out);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_full_q    <= 1'b0;
      req_msg_q     <= '0;
      req_dom_q     <= 1'b0;
      for (int i = 0; i < c_depth; i++) dfifo_q[i] <= 1'b0;
      dwr_q         <= '0;
      drd_q         <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < 2; i++) begin
        rf_msg_q[i]  <= '0;
        rf_dom_q[i]  <= 1'b0;
        rf_fail_q[i] <= 1'b0;
      end
      rf_wr_q       <= 1'b0;
      rf_rd_q       <= 1'b0;
      rf_cnt_q      <= '0;
      fail_count_q  <= '0;
      domain_err_q  <= 1'b0;
    end else begin
      req_full_q    <= req_full_d;
      req_msg_q     <= req_msg_d;
      req_dom_q     <= req_dom_d;
      dfifo_q       <= dfifo_d;
      dwr_q         <= dwr_d;
      drd_q         <= drd_d;
      outstanding_q <= outstanding_d;
      rf_msg_q      <= rf_msg_d;
      rf_dom_q      <= rf_dom_d;
      rf_fail_q     <= rf_fail_d;
      rf_wr_q       <= rf_wr_d;
      rf_rd_q       <= rf_rd_d;
      rf_cnt_q      <= rf_cnt_d;
      fail_count_q  <= fail_count_d;
      domain_err_q  <= domain_err_d;
    end
  end
endmodule

// File: tb/tb_plab5_mcore_mem_req_tracker.sv
// Directed bench for plab5_mcore_mem_req_tracker: a small behavioural model fills a
// scoreboard queue as responses are driven; entries are compared when proc_resp fires.
module tb_plab5_mcore_mem_req_tracker;
  localparam int RQ = 77;
  localparam int RS = 45;

  logic clk = 1'b0;
  logic reset, mode;
  logic [RQ-1:0] proc_req_msg;
  logic proc_req_domain, proc_req_val, proc_req_rdy;
  logic [RQ-1:0] net_req_msg;
  logic net_req_domain, net_req_val, net_req_rdy;
  logic [RS-1:0] net_resp_msg;
  logic net_resp_domain, net_resp_fail, net_resp_val, net_resp_rdy;
  logic [RS-1:0] proc_resp_msg;
  logic proc_resp_domain, proc_resp_fail, proc_resp_val, proc_resp_rdy;
  logic [2:0] outstanding;
  logic [7:0] fail_count;
  logic domain_err;

  plab5_mcore_mem_req_tracker dut (
    .clk(clk), .reset(reset), .mode(mode),
    .proc_req_msg(proc_req_msg), .proc_req_domain(proc_req_domain),
    .proc_req_val(proc_req_val), .proc_req_rdy(proc_req_rdy),
    .net_req_msg(net_req_msg), .net_req_domain(net_req_domain),
    .net_req_val(net_req_val), .net_req_rdy(net_req_rdy),
    .net_resp_msg(net_resp_msg), .net_resp_domain(net_resp_domain),
    .net_resp_fail(net_resp_fail), .net_resp_val(net_resp_val), .net_resp_rdy(net_resp_rdy),
    .proc_resp_msg(proc_resp_msg), .proc_resp_domain(proc_resp_domain),
    .proc_resp_fail(proc_resp_fail), .proc_resp_val(proc_resp_val), .proc_resp_rdy(proc_resp_rdy),
    .outstanding(outstanding), .fail_count(fail_count), .domain_err(domain_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [RS-1:0] msg;
    logic          dom;
    logic          fail;
  } resp_t;

  resp_t exp_q[$];
  logic  dom_q[$];
  int    total = 0;
  int    bad = 0;
  int    mfc = 0;
  logic  mderr = 1'b0;

  function automatic logic [RQ-1:0] mk_req(input logic [31:0] addr);
    return {3'd0, addr[7:0], addr, 2'd0, addr ^ 32'h5a5a_0000};
  endfunction

  function automatic logic [RS-1:0] mk_resp(input logic [31:0] data);
    return {3'd0, data[7:0], 2'd0, data};
  endfunction

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_net_req_val"}, 80'(net_req_val), 80'(0));
    chk({tag, "_proc_resp_val"}, 80'(proc_resp_val), 80'(0));
    chk({tag, "_net_resp_rdy"}, 80'(net_resp_rdy), 80'(1));
    chk({tag, "_proc_req_rdy"}, 80'(proc_req_rdy), 80'(1));
    chk({tag, "_outstanding"}, 80'(outstanding), 80'(0));
  endtask

  // Expected response for one accepted net response, from the bench's own domain FIFO.
  task automatic model_resp(input logic dom, input logic [31:0] data, input logic fail);
    resp_t r;
    logic e;
    if (dom_q.size() == 0) begin
      mderr = 1'b1;
    end else begin
      e = dom_q.pop_front();
      r.msg = mk_resp(data); r.dom = dom; r.fail = fail;
      if (mode && dom != e) begin
        r.msg[31:0] = '0; r.fail = 1'b1; r.dom = e; mderr = 1'b1;
      end else if (fail) begin
        r.msg[31:0] = '0;
      end
      if (r.fail && mfc < 255) mfc++;
      exp_q.push_back(r);
    end
  endtask

  task automatic send_req(input logic dom, input logic [31:0] addr);
    int n = 0;
    proc_req_msg = mk_req(addr); proc_req_domain = dom; proc_req_val = 1'b1;
    #1;
    while (!proc_req_rdy && n < 50) begin @(negedge clk); #1; n++; end
    chk("req_accept_wait", 80'(n < 50), 80'(1));
    dom_q.push_back(dom);
    @(negedge clk);
    proc_req_val = 1'b0;
  endtask

  task automatic send_resp(input logic dom, input logic [31:0] data, input logic fail);
    int n = 0;
    net_resp_msg = mk_resp(data); net_resp_domain = dom; net_resp_fail = fail;
    net_resp_val = 1'b1;
    #1;
    while (!net_resp_rdy && n < 50) begin @(negedge clk); #1; n++; end
    chk("resp_accept_wait", 80'(n < 50), 80'(1));
    model_resp(dom, data, fail);
    @(negedge clk);
    net_resp_val = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    resp_t r;
    proc_resp_rdy = 1'b1;
    #1;
    while (exp_q.size() > 0 && n < 50) begin
      if (proc_resp_val) begin
        r = exp_q.pop_front();
        chk("resp_msg", 80'(proc_resp_msg), 80'(r.msg));
        chk("resp_dom", 80'(proc_resp_domain), 80'(r.dom));
        chk("resp_fail", 80'(proc_resp_fail), 80'(r.fail));
      end
      @(negedge clk); #1; n++;
    end
    chk("drain_left", 80'(exp_q.size()), 80'(0));
    proc_resp_rdy = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    proc_req_val = 1'b0; net_resp_val = 1'b0; proc_resp_rdy = 1'b0;
    dom_q.delete(); exp_q.delete(); mfc = 0; mderr = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, sent;
    reset = 1'b0; mode = 1'b1;
    proc_req_msg = '0; proc_req_domain = 1'b0; proc_req_val = 1'b0;
    net_req_rdy = 1'b1;
    net_resp_msg = '0; net_resp_domain = 1'b0; net_resp_fail = 1'b0; net_resp_val = 1'b0;
    proc_resp_rdy = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); #1;

    check_idle("reset");
    chk("reset_fail_count", 80'(fail_count), 80'(0));
    chk("reset_domain_err", 80'(domain_err), 80'(0));

    // Single request, domain 0, mode 1
    proc_req_msg = mk_req(32'h100); proc_req_domain = 1'b0; proc_req_val = 1'b1;
    dom_q.push_back(1'b0);
    @(negedge clk); proc_req_val = 1'b0; #1;
    chk("single_net_req_val", 80'(net_req_val), 80'(1));
    chk("single_net_req_msg", 80'(net_req_msg), 80'(mk_req(32'h100)));
    chk("single_net_req_dom", 80'(net_req_domain), 80'(0));
    chk("single_out_before", 80'(outstanding), 80'(0));
    @(negedge clk); #1;
    chk("single_out_after", 80'(outstanding), 80'(1));
    chk("single_net_req_idle", 80'(net_req_val), 80'(0));
    send_resp(1'b0, 32'hdead_beef, 1'b0); #1;
    chk("single_out_done", 80'(outstanding), 80'(0));
    chk("single_resp_val", 80'(proc_resp_val), 80'(1));
    drain();
    chk("single_fail_count", 80'(fail_count), 80'(0));

    // Network stall: request must hold steady while net_req_rdy=0
    net_req_rdy = 1'b0;
    send_req(1'b1, 32'h200);
    repeat (2) begin
      #1;
      chk("stall_val", 80'(net_req_val), 80'(1));
      chk("stall_msg", 80'(net_req_msg), 80'(mk_req(32'h200)));
      chk("stall_proc_rdy", 80'(proc_req_rdy), 80'(0));
      @(negedge clk);
    end
    net_req_rdy = 1'b1;
    @(negedge clk); #1;
    chk("stall_out", 80'(outstanding), 80'(1));
    send_resp(1'b1, 32'hcafe_0001, 1'b0);
    drain();

    // Domain mismatch with checking on
    send_req(1'b1, 32'h300);
    @(negedge clk);
    send_resp(1'b0, 32'h1234_5678, 1'b0);
    drain();
    chk("mismatch_domain_err", 80'(domain_err), 80'(mderr));
    chk("mismatch_fail_count", 80'(fail_count), 80'(mfc));

    // Network-reported failure
    send_req(1'b0, 32'h400);
    @(negedge clk);
    send_resp(1'b0, 32'haaaa_5555, 1'b1);
    drain();
    chk("netfail_fail_count", 80'(fail_count), 80'(mfc));
    chk("netfail_domain_err_sticky", 80'(domain_err), 80'(1));

    // Same mismatch stimulus with checking off
    do_reset();
    mode = 1'b0;
    send_req(1'b1, 32'h500);
    @(negedge clk);
    send_resp(1'b0, 32'h1234_5678, 1'b0);
    drain();
    chk("mode0_domain_err", 80'(domain_err), 80'(0));
    chk("mode0_fail_count", 80'(fail_count), 80'(0));
    mode = 1'b1;

    // Back-to-back requests up to the outstanding limit
    acc = 0;
    proc_req_msg = mk_req(32'h600); proc_req_domain = 1'b0; proc_req_val = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (proc_req_rdy) begin acc++; dom_q.push_back(1'b0); end
      @(negedge clk);
    end
    proc_req_val = 1'b0; #1;
    chk("limit_accepted", 80'(acc), 80'(4));
    chk("limit_outstanding", 80'(outstanding), 80'(4));
    chk("limit_proc_rdy", 80'(proc_req_rdy), 80'(0));
    send_resp(1'b0, 32'h0000_1000, 1'b0); #1;
    chk("limit_proc_rdy_again", 80'(proc_req_rdy), 80'(1));
    chk("limit_outstanding_3", 80'(outstanding), 80'(3));
    drain();

    // Response FIFO back-pressure with three responses pending
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      if (sent < 3) begin
        net_resp_msg = mk_resp(32'h7000 + sent); net_resp_domain = 1'b0;
        net_resp_fail = 1'b0; net_resp_val = 1'b1;
      end
      #1;
      if (sent < 3 && net_resp_rdy) begin
        model_resp(1'b0, 32'h7000 + sent, 1'b0);
        sent++;
      end
      @(negedge clk);
    end
    net_resp_val = 1'b0; #1;
    chk("bp_accepted", 80'(sent), 80'(2));
    chk("bp_net_resp_rdy", 80'(net_resp_rdy), 80'(0));
    drain();
    send_resp(1'b0, 32'h7002, 1'b0);
    drain();
    chk("bp_outstanding", 80'(outstanding), 80'(0));

    // Unexpected response with nothing outstanding
    send_resp(1'b1, 32'h0000_0bad, 1'b0);
    repeat (2) begin
      #1;
      chk("orphan_resp_val", 80'(proc_resp_val), 80'(0));
      @(negedge clk);
    end
    chk("orphan_domain_err", 80'(domain_err), 80'(mderr));
    chk("orphan_outstanding", 80'(outstanding), 80'(0));

    // Reset in the middle of traffic
    send_req(1'b0, 32'h800);
    @(negedge clk);
    send_resp(1'b0, 32'h0000_0888, 1'b0);
    net_req_rdy = 1'b0;
    send_req(1'b1, 32'h900);
    #2;
    reset = 1'b0;
    #1;
    check_idle("midreset");
    chk("midreset_domain_err", 80'(domain_err), 80'(0));
    chk("midreset_fail_count", 80'(fail_count), 80'(0));
    dom_q.delete(); exp_q.delete(); mderr = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    net_req_rdy = 1'b1;
    @(negedge clk); #1;
    check_idle("postreset");
    send_resp(1'b0, 32'h0000_0999, 1'b0);
    #1;
    chk("postreset_discard_val", 80'(proc_resp_val), 80'(0));
    chk("postreset_domain_err", 80'(domain_err), 80'(mderr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
